// File: rtl/uart_rx_deserializer_if.sv
// Receive-side byte bus leaving the UART deserializer.
//   data_out   : last correctly received byte
//   data_valid : one-cycle strobe, data_out updated on the same edge
//   frame_err  : one-cycle strobe, stop bit sampled low
//   busy       : receiver is inside a frame (FSM not idle)
// master = deserializer (drives), slave = consumer (command decoder).
interface uart_rx_deserializer_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (output data_out, data_valid, frame_err, busy);
  modport slave  (input  data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive deserializer with mid-bit sampling.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   rx     : raw asynchronous serial line (idles high)
//   out_if : byte bus (data_out / data_valid / frame_err / busy)
// Glitches shorter than half a bit are rejected at the start-bit centre;
// a low stop bit raises frame_err and parks in BREAK until the line idles.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  uart_rx_deserializer_if.master out_if
);
  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'(HALF_BIT);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      dout_q;
  logic            dv_q, fe_q;
  logic            dv_d, fe_d, sample_data;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    dv_d        = 1'b0;
    fe_d        = 1'b0;
    sample_data = 1'b0;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (cnt == HALF_C) state_d = rx_s ? IDLE : DATA;
      DATA: if (cnt == LAST_C) begin
        sample_data = 1'b1;
        if (bit_idx == 3'd7) state_d = STOP;
      end
      // Leaving at the stop-bit centre lets a start bit that follows
      // immediately be caught with no idle gap.
      STOP: if (cnt == LAST_C) begin
        state_d = rx_s ? IDLE : BREAK;
        dv_d    = rx_s;
        fe_d    = !rx_s;
      end
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timer: restarts on every state change and at each data-bit centre.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   cnt <= '0;
    else if (state_d != state_q)                cnt <= '0;
    else if (state_q inside {START, DATA, STOP}) cnt <= (cnt == LAST_C) ? '0 : cnt + CW'(1);
    else                                        cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx <= '0;
      shift   <= '0;
    end else if (state_q == START) begin
      bit_idx <= '0;
    end else if (sample_data) begin
      shift[bit_idx] <= rx_s;   // LSB first
      bit_idx        <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      dv_q <= dv_d;
      fe_q <= fe_d;
      if (dv_d) dout_q <= shift;
    end
  end

  assign out_if.data_out   = dout_q;
  assign out_if.data_valid = dv_q;
  assign out_if.frame_err  = fe_q;
  assign out_if.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;
  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  localparam int LAT_MIN = 2 + HALF + 9 * CPB + 1;
  localparam int LAT_MAX = 2 + HALF + 9 * CPB + 3;

  typedef struct {
    logic [7:0] b;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   fe_exp = 0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;

  uart_rx_deserializer_if u_if ();

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .out_if (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clk) begin
    if (rst) begin
      if (u_if.data_valid) begin
        check("dv_width", {31'd0, prev_dv}, 32'd0);
        check("dv_fe_excl", {31'd0, u_if.frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_dv: got data 0x%0h, expected no strobe", u_if.data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", {24'd0, u_if.data_out}, {24'd0, e.b});
          n_tests++;
          if ((cyc - e.t0) < LAT_MIN || (cyc - e.t0) > LAT_MAX) begin
            n_fail++;
            $display("FAIL latency: got %0d, expected %0d..%0d", cyc - e.t0, LAT_MIN, LAT_MAX);
          end
        end
      end
      if (u_if.frame_err) begin
        check("fe_width", {31'd0, prev_fe}, 32'd0);
        n_tests++;
        if (fe_exp == 0) begin
          n_fail++;
          $display("FAIL unexpected_fe: got frame_err=1, expected 0");
        end else begin
          fe_exp--;
        end
      end
    end
    prev_dv = u_if.data_valid;
    prev_fe = u_if.frame_err;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // stop_low = 0: normal frame (byte expected); otherwise stop held low
  // for that many bit times and a frame error is expected.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    exp_t e;
    @(negedge clk);
    rx = 1'b0;
    e.b  = b;
    e.t0 = cyc;
    if (stop_low == 0) exp_q.push_back(e);
    else               fe_exp++;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (stop_low != 0) hold(1'b0, stop_low * CPB);
    rx = 1'b1;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fe_exp != 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size() + fe_exp, 0);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_data"}, {24'd0, u_if.data_out}, 32'd0);
    check({name, "_dv"},   {31'd0, u_if.data_valid}, 32'd0);
    check({name, "_fe"},   {31'd0, u_if.frame_err}, 32'd0);
    check({name, "_busy"}, {31'd0, u_if.busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] f;
    #1 check_reset_outs("rst0");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outs("idle");

    // Single byte 'L'
    send_frame(8'h4C, 0);
    drain("drain_L");
    repeat (4) @(negedge clk);
    check("busy_after_L", {31'd0, u_if.busy}, 32'd0);
    check("hold_L", {24'd0, u_if.data_out}, 32'h4C);

    // Back-to-back, no idle gap
    send_frame(8'h46, 0);
    send_frame(8'h41, 0);
    send_frame(8'h61, 0);
    drain("drain_b2b");
    repeat (10) @(negedge clk);

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy", {31'd0, u_if.busy}, 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_idle", {31'd0, u_if.busy}, 32'd0);
    check("glitch_hold", {24'd0, u_if.data_out}, 32'h61);

    // Framing error with stop held low, then recovery
    send_frame(8'h99, 3);
    drain("drain_fe");
    check("fe_hold", {24'd0, u_if.data_out}, 32'h61);
    repeat (10) @(negedge clk);
    send_frame(8'h6C, 0);
    drain("drain_l");
    repeat (10) @(negedge clk);

    // Reset asserted between edges during data bit 4 of 'f'
    f = 8'h66;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) hold(f[i], CPB);
    rx = f[4];
    repeat (CPB / 2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outs("async_rst");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_reset_outs("post_rst");
    send_frame(8'h66, 0);
    drain("drain_f");
    repeat (10) @(negedge clk);
    check("final_data", {24'd0, u_if.data_out}, 32'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
